// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Round-robin arbiter merging the instruction-fetch and data ports
//            onto the single SRAM-controller request interface.
//            Define SRAM_ARB_TIMEOUT_EN to add the WAIT timeout and DRAIN state.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_stb,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_dtr,
  input  logic        d_stb,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_dtw,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_dtr,
  output logic        mem_stb,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dtw,
  input  logic        mem_ack,
  input  logic [31:0] mem_dtr
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_timeout_cyc_range
    $error("sram_arbiter: TIMEOUT_CYC must be within 2..255");
  end

  logic [2:0]  state, state_nxt;
  logic        last, last_nxt;
  logic        gnt_d, gnt_d_nxt;
  logic        pick_d;
  logic        mem_stb_nxt, mem_rw_nxt;
  logic [31:0] mem_addr_nxt, mem_dtw_nxt;
  logic        i_ack_nxt, d_ack_nxt;
  logic [31:0] i_dtr_nxt, d_dtr_nxt;
  logic        timeout;

`ifdef SRAM_ARB_TIMEOUT_EN
  // The count lands on TIMEOUT_CYC at the edge ending the last permitted WAIT cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       i_err_nxt, d_err_nxt;

  assign timeout = (state == ST_WAIT) && !mem_ack && (wait_cnt == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
  assign i_err   = 1'b0;
  assign d_err   = 1'b0;
`endif

  // On a tie the master that was not granted last time wins.
  assign pick_d = d_stb && (!i_stb || !last);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      gnt_d    <= 1'b0;
      mem_stb  <= 1'b0;
      mem_rw   <= 1'b0;
      mem_addr <= '0;
      mem_dtw  <= '0;
      i_ack    <= 1'b0;
      i_dtr    <= '0;
      d_ack    <= 1'b0;
      d_dtr    <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      wait_cnt <= '0;
      i_err    <= 1'b0;
      d_err    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      gnt_d    <= gnt_d_nxt;
      mem_stb  <= mem_stb_nxt;
      mem_rw   <= mem_rw_nxt;
      mem_addr <= mem_addr_nxt;
      mem_dtw  <= mem_dtw_nxt;
      i_ack    <= i_ack_nxt;
      i_dtr    <= i_dtr_nxt;
      d_ack    <= d_ack_nxt;
      d_dtr    <= d_dtr_nxt;
`ifdef SRAM_ARB_TIMEOUT_EN
      wait_cnt <= wait_cnt_nxt;
      i_err    <= i_err_nxt;
      d_err    <= d_err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_stb || d_stb) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack)      state_nxt = ST_DONE;
        else if (timeout) state_nxt = ST_DRAIN;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_DRAIN: if (mem_ack) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    last_nxt     = last;
    gnt_d_nxt    = gnt_d;
    mem_stb_nxt  = 1'b0;
    mem_rw_nxt   = mem_rw;
    mem_addr_nxt = mem_addr;
    mem_dtw_nxt  = mem_dtw;
    i_ack_nxt    = 1'b0;
    i_dtr_nxt    = i_dtr;
    d_ack_nxt    = 1'b0;
    d_dtr_nxt    = d_dtr;
`ifdef SRAM_ARB_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt + 8'd1;
    i_err_nxt    = 1'b0;
    d_err_nxt    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (i_stb || d_stb) begin
          last_nxt     = pick_d;
          gnt_d_nxt    = pick_d;
          mem_stb_nxt  = 1'b1;
          mem_rw_nxt   = pick_d && d_rw;
          mem_addr_nxt = pick_d ? d_addr : i_addr;
          mem_dtw_nxt  = pick_d ? d_dtw : 32'h0;
        end
      end
      ST_ISSUE: begin
`ifdef SRAM_ARB_TIMEOUT_EN
        wait_cnt_nxt = '0;
`endif
      end
      ST_WAIT: begin
        if (mem_ack) begin
          if (gnt_d) begin
            d_ack_nxt = 1'b1;
            d_dtr_nxt = mem_dtr;
          end else begin
            i_ack_nxt = 1'b1;
            i_dtr_nxt = mem_dtr;
          end
        end else if (timeout) begin
          if (gnt_d) begin
            d_ack_nxt = 1'b1;
            d_dtr_nxt = 32'hFFFF_FFFF;
          end else begin
            i_ack_nxt = 1'b1;
            i_dtr_nxt = 32'hFFFF_FFFF;
          end
`ifdef SRAM_ARB_TIMEOUT_EN
          d_err_nxt = gnt_d;
          i_err_nxt = !gnt_d;
`endif
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed self-checking bench for sram_arbiter with a small
//            fixed-latency SRAM controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack, i_err;
  logic [31:0] i_dtr;
  logic        d_stb = 1'b0;
  logic        d_rw = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_dtw = '0;
  logic        d_ack, d_err;
  logic [31:0] d_dtr;
  logic        mem_stb, mem_rw;
  logic [31:0] mem_addr, mem_dtw;
  logic        mem_ack;
  logic [31:0] mem_dtr;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .i_stb(i_stb), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_dtr(i_dtr),
    .d_stb(d_stb), .d_rw(d_rw), .d_addr(d_addr), .d_dtw(d_dtw),
    .d_ack(d_ack), .d_err(d_err), .d_dtr(d_dtr),
    .mem_stb(mem_stb), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_dtw(mem_dtw),
    .mem_ack(mem_ack), .mem_dtr(mem_dtr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Controller model: acks ctrl_lat cycles after seeing mem_stb, checking request hold.
  logic        ctrl_on    = 1'b1;
  int          ctrl_lat   = 5;
  logic [31:0] ctrl_rdata = 32'hDEAD_BEEF;
  logic        model_ack  = 1'b0;
  logic        force_ack  = 1'b0;
  int          hold_err   = 0;

  assign mem_ack = model_ack | force_ack;
  assign mem_dtr = ctrl_rdata;

  initial begin : ctrl_model
    logic [64:0] cap;
    forever begin
      @(posedge clk); #1;
      if (mem_stb && ctrl_on) begin
        cap = {mem_rw, mem_addr, mem_dtw};
        for (int k = 0; k < ctrl_lat; k++) begin
          @(posedge clk); #1;
          if ({mem_rw, mem_addr, mem_dtw} !== cap) hold_err++;
        end
        model_ack = 1'b1;
        @(posedge clk); #1;
        model_ack = 1'b0;
      end
    end
  end

  int          stb_cnt = 0;
  int          i_ack_cnt = 0;
  int          d_ack_cnt = 0;
  logic [64:0] stb_log[$];

  always @(negedge clk) begin
    if (mem_stb) begin
      stb_cnt++;
      stb_log.push_back({mem_rw, mem_addr, mem_dtw});
    end
    if (i_ack) i_ack_cnt++;
    if (d_ack) d_ack_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic master_xfer(input bit is_d, input bit rw, input logic [31:0] addr,
                             input logic [31:0] dtw, input bit hold_extra,
                             output int lat, output logic [31:0] dtr, output logic err);
    lat = 0;
    dtr = '0;
    err = 1'b0;
    if (is_d) begin
      d_rw = rw; d_addr = addr; d_dtw = dtw; d_stb = 1'b1;
    end else begin
      i_addr = addr; i_stb = 1'b1;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (is_d ? d_ack : i_ack) begin
        lat = n;
        dtr = is_d ? d_dtr : i_dtr;
        err = is_d ? d_err : i_err;
        break;
      end
    end
    check(is_d ? "d_ack_seen" : "i_ack_seen", 96'(lat != 0), 96'(1));
    if (hold_extra) begin
      @(posedge clk); #1;
    end
    if (is_d) d_stb = 1'b0; else i_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : main
    int          lat, lat_b;
    logic [31:0] dtr, dtr_b;
    logic        err, err_b;
    int          s0, ia0, da0, lb;
    logic [31:0] tie_addr[4];

    // Reset state
    cycles(3);
    check("rst_ctrl", {mem_stb, mem_rw, i_ack, d_ack, i_err, d_err}, 96'h0);
    check("rst_mem", {mem_addr, mem_dtw}, 96'h0);
    check("rst_dtr", {i_dtr, d_dtr}, 96'h0);
    reset = 1'b0;
    cycles(1);

    // Instruction read alone
    s0 = stb_cnt; ia0 = i_ack_cnt; da0 = d_ack_cnt; lb = stb_log.size();
    master_xfer(1'b0, 1'b0, 32'h100, 32'h0, 1'b0, lat, dtr, err);
    check("ird_latency", 96'(lat), 96'(7));
    check("ird_dtr", 96'(dtr), 96'hDEAD_BEEF);
    check("ird_err", 96'(err), 96'(0));
    cycles(3);
    check("ird_stb_cnt", 96'(stb_cnt - s0), 96'(1));
    check("ird_req", 96'(stb_log[lb]), {31'h0, 1'b0, 32'h100, 32'h0});
    check("ird_ack_cnts", {32'(i_ack_cnt - ia0), 32'(d_ack_cnt - da0)}, {32'd1, 32'd0});

    // Data write alone
    s0 = stb_cnt; ia0 = i_ack_cnt; da0 = d_ack_cnt; lb = stb_log.size();
    ctrl_rdata = 32'h5555_AAAA;
    master_xfer(1'b1, 1'b1, 32'h203, 32'h1122_3344, 1'b0, lat, dtr, err);
    check("dwr_latency", 96'(lat), 96'(7));
    cycles(3);
    check("dwr_req", 96'(stb_log[lb]), {31'h0, 1'b1, 32'h203, 32'h1122_3344});
    check("dwr_hold", 96'(hold_err), 96'(0));
    check("dwr_counts", {32'(stb_cnt - s0), 32'(i_ack_cnt - ia0), 32'(d_ack_cnt - da0)},
          {32'd1, 32'd0, 32'd1});

    // Simultaneous requests straight out of reset
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    s0 = stb_cnt; ia0 = i_ack_cnt; da0 = d_ack_cnt; lb = stb_log.size();
    tie_addr[0] = 32'h1000; tie_addr[1] = 32'h2000;
    tie_addr[2] = 32'h1000; tie_addr[3] = 32'h2000;
    fork
      begin
        master_xfer(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, lat, dtr, err);
        master_xfer(1'b0, 1'b0, 32'h1000, 32'h0, 1'b0, lat, dtr, err);
      end
      begin
        master_xfer(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, lat_b, dtr_b, err_b);
        master_xfer(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, lat_b, dtr_b, err_b);
      end
    join
    cycles(3);
    check("tie_counts", {32'(stb_cnt - s0), 32'(i_ack_cnt - ia0), 32'(d_ack_cnt - da0)},
          {32'd4, 32'd2, 32'd2});
    for (int k = 0; k < 4; k++) begin
      if (lb + k < stb_log.size())
        check($sformatf("tie_grant%0d", k), 96'(stb_log[lb + k][63:32]), 96'(tie_addr[k]));
      else
        check($sformatf("tie_grant%0d_present", k), 96'(0), 96'(1));
    end

    // Master holds stb through its ack cycle
    s0 = stb_cnt; ia0 = i_ack_cnt;
    master_xfer(1'b0, 1'b0, 32'h180, 32'h0, 1'b1, lat, dtr, err);
    cycles(4);
    check("hold_thru_ack", {32'(stb_cnt - s0), 32'(i_ack_cnt - ia0)}, {32'd1, 32'd1});

    // Reset while waiting on the controller
    ctrl_on = 1'b0;
    d_rw = 1'b0; d_addr = 32'h300; d_dtw = 32'h0; d_stb = 1'b1;
    begin : wait_stb
      for (int n = 0; n < 10; n++) begin
        cycles(1);
        if (mem_stb) disable wait_stb;
      end
    end
    check("rwait_issued", 96'(mem_stb), 96'(1));
    cycles(2);
    reset = 1'b1;
    d_stb = 1'b0;
    cycles(1);
    check("rwait_ctrl", {mem_stb, mem_rw, i_ack, d_ack, i_err, d_err}, 96'h0);
    check("rwait_mem", {mem_addr, mem_dtw}, 96'h0);
    check("rwait_dtr", {i_dtr, d_dtr}, 96'h0);
    reset = 1'b0;
    cycles(1);
    s0 = stb_cnt; ia0 = i_ack_cnt; da0 = d_ack_cnt;
    force_ack = 1'b1;
    cycles(1);
    force_ack = 1'b0;
    cycles(3);
    check("stray_ack", {32'(stb_cnt - s0), 32'(i_ack_cnt - ia0), 32'(d_ack_cnt - da0)}, 96'h0);
    ctrl_on = 1'b1;
    ctrl_rdata = 32'hCAFE_F00D;
    lb = stb_log.size();
    master_xfer(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, lat, dtr, err);
    check("post_rst_rd", {32'(lat), dtr}, {32'd7, 32'hCAFE_F00D});
    check("post_rst_req", 96'(stb_log[lb]), {31'h0, 1'b0, 32'h400, 32'h0});

`ifdef SRAM_ARB_TIMEOUT_EN
    // Controller never answers: abort after 8 WAIT cycles, then drain
    cycles(2);
    ctrl_on = 1'b0;
    master_xfer(1'b0, 1'b0, 32'h600, 32'h0, 1'b0, lat, dtr, err);
    check("to_result", {32'(lat), dtr, 31'h0, err}, {32'd10, 32'hFFFF_FFFF, 32'd1});
    s0 = stb_cnt;
    d_rw = 1'b0; d_addr = 32'h500; d_stb = 1'b1;
    cycles(5);
    check("to_drain_block", 96'(stb_cnt - s0), 96'(0));
    ctrl_on = 1'b1;
    ctrl_rdata = 32'h0BAD_CAFE;
    force_ack = 1'b1;
    cycles(1);
    force_ack = 1'b0;
    master_xfer(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, lat, dtr, err);
    check("to_after_drain", {dtr, 31'h0, err}, {32'h0BAD_CAFE, 32'd0});
`endif

    cycles(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
